// File: rtl/riscv_main_controller.sv
// Main control decoder for the RV32I pipeline: decodes the ID-stage opcode and
// registers the resulting control bundle into the ID/EX control register.
module riscv_main_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       valid_in,
    input  logic       stall,
    input  logic       flush,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       Jump,
    output logic       Jalr,
    output logic [1:0] ALUSrcA,
    output logic       Illegal,
    output logic       valid_out
);

    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpRType  = 2'b10;
    localparam logic [1:0] AluOpIType  = 2'b11;

    localparam logic [1:0] SrcARs1  = 2'b00;
    localparam logic [1:0] SrcAPc   = 2'b01;
    localparam logic [1:0] SrcAZero = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic [1:0] alu_src_a;
        logic       illegal;
        logic       valid;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // An all-zero bundle is a bubble; unknown opcodes (including X/Z) fall to default.
    always_comb begin
        dec = '0;
        if (valid_in) begin
            dec.valid = 1'b1;
            case (Opcode)
                OpRType: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = AluOpRType;
                end
                OpIAlu: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = AluOpIType;
                end
                OpLoad: begin
                    dec.alu_src    = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.alu_op     = AluOpAdd;
                end
                OpStore: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                    dec.alu_op    = AluOpAdd;
                end
                OpBranch: begin
                    dec.branch = 1'b1;
                    dec.alu_op = AluOpBranch;
                end
                OpJal: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.jump      = 1'b1;
                    dec.alu_src_a = SrcAPc;
                end
                OpJalr: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.jump      = 1'b1;
                    dec.jalr      = 1'b1;
                    dec.alu_src_a = SrcARs1;
                end
                OpLui: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_src_a = SrcAZero;
                end
                OpAuipc: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_src_a = SrcAPc;
                end
                default: begin
                    dec.illegal = 1'b1;
                end
            endcase
        end
    end

    // Flush wins over stall so a squashed instruction never survives a held stage.
    always_comb begin
        ctrl_d = ctrl_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d = dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        ALUSrc    = ctrl_q.alu_src;
        MemtoReg  = ctrl_q.mem_to_reg;
        RegWrite  = ctrl_q.reg_write;
        MemRead   = ctrl_q.mem_read;
        MemWrite  = ctrl_q.mem_write;
        Branch    = ctrl_q.branch;
        ALUOp     = ctrl_q.alu_op;
        Jump      = ctrl_q.jump;
        Jalr      = ctrl_q.jalr;
        ALUSrcA   = ctrl_q.alu_src_a;
        Illegal   = ctrl_q.illegal;
        valid_out = ctrl_q.valid;
    end

    a_mem_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(MemRead && MemWrite));
    a_jalr_jump: assert property (@(posedge clk) disable iff (reset)
        Jalr |-> Jump);
    a_illegal_clean: assert property (@(posedge clk) disable iff (reset)
        Illegal |-> !(ALUSrc || MemtoReg || RegWrite || MemRead || MemWrite || Branch ||
                      Jump || Jalr || (ALUOp != 2'b00) || (ALUSrcA != 2'b00)));

endmodule

// File: tb/tb_riscv_main_controller.sv
// Self-checking bench for riscv_main_controller: a table-driven reference decode
// plus a registered-stage model, exercised by directed and random stimulus.
module tb_riscv_main_controller;

    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic       valid_in;
    logic       stall;
    logic       flush;
    logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0] ALUOp;
    logic       Jump, Jalr;
    logic [1:0] ALUSrcA;
    logic       Illegal, valid_out;

    int checks;
    int failures;

    riscv_main_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .valid_in  (valid_in),
        .stall     (stall),
        .flush     (flush),
        .ALUSrc    (ALUSrc),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .Jump      (Jump),
        .Jalr      (Jalr),
        .ALUSrcA   (ALUSrcA),
        .Illegal   (Illegal),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector, order: ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp Jump Jalr
    // ALUSrcA Illegal valid_out
    logic [13:0] obs;
    assign obs = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
                  Jump, Jalr, ALUSrcA, Illegal, valid_out};

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, AUIPC_OP = 7'b0010111;

    logic [6:0]  tbl_op  [9];
    logic [13:0] tbl_ctl [9];
    logic [13:0] exp_q;

    function automatic logic [13:0] mk(input logic as, input logic m2r, input logic rw,
                                       input logic mr, input logic mw, input logic br,
                                       input logic [1:0] aop, input logic j, input logic jr,
                                       input logic [1:0] sa);
        return {as, m2r, rw, mr, mw, br, aop, j, jr, sa, 1'b0, 1'b1};
    endfunction

    task automatic init_table();
        tbl_op[0] = R_OP;     tbl_ctl[0] = mk(0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 2'b00);
        tbl_op[1] = I_OP;     tbl_ctl[1] = mk(1, 0, 1, 0, 0, 0, 2'b11, 0, 0, 2'b00);
        tbl_op[2] = LD_OP;    tbl_ctl[2] = mk(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 2'b00);
        tbl_op[3] = ST_OP;    tbl_ctl[3] = mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00);
        tbl_op[4] = BR_OP;    tbl_ctl[4] = mk(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 2'b00);
        tbl_op[5] = JAL_OP;   tbl_ctl[5] = mk(1, 0, 1, 0, 0, 0, 2'b00, 1, 0, 2'b01);
        tbl_op[6] = JALR_OP;  tbl_ctl[6] = mk(1, 0, 1, 0, 0, 0, 2'b00, 1, 1, 2'b00);
        tbl_op[7] = LUI_OP;   tbl_ctl[7] = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b10);
        tbl_op[8] = AUIPC_OP; tbl_ctl[8] = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b01);
    endtask

    function automatic logic [13:0] ref_decode(input logic [6:0] op, input logic v);
        if (!v) return 14'd0;
        for (int i = 0; i < 9; i++) begin
            if (op === tbl_op[i]) return tbl_ctl[i];
        end
        return 14'b00000000000011;
    endfunction

    // One clock of stimulus; model updates with the inputs seen at the edge.
    task automatic cycle(input logic [6:0] op, input logic v, input logic st, input logic fl);
        Opcode = op; valid_in = v; stall = st; flush = fl;
        @(posedge clk);
        if (fl) exp_q = 14'd0;
        else if (!st) exp_q = ref_decode(op, v);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Opcode = 7'd0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        exp_q = 14'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 14'd0) begin
            failures++; $display("FAIL reset_initial: got %b expected %b", obs, 14'd0);
        end
        reset = 1'b0;
        cycle(R_OP, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_q) begin
            failures++; $display("FAIL reset_prelatch: got %b expected %b", obs, exp_q);
        end
        #2 reset = 1'b1;
        #1;
        exp_q = 14'd0;
        checks++;
        if (obs !== 14'd0) begin
            failures++; $display("FAIL reset_async: got %b expected %b", obs, 14'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(R_OP, 1'b1, 1'b0, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || ALUOp !== 2'b10 || valid_out !== 1'b1 || obs !== exp_q) begin
            failures++; $display("FAIL reset_release: got %b expected %b", obs, exp_q);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] ops [9];
        ops = '{LUI_OP, AUIPC_OP, JAL_OP, JALR_OP, BR_OP, LD_OP, ST_OP, I_OP, R_OP};
        for (int i = 0; i < 9; i++) begin
            cycle(ops[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_q) begin
                failures++;
                $display("FAIL sweep_op_%b: got %b expected %b", ops[i], obs, exp_q);
            end
        end
        cycle(LD_OP, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp} !== 8'b11110000) begin
            failures++; $display("FAIL sweep_load_fields: got %b expected %b", obs[13:6],
                                 8'b11110000);
        end
    endtask

    task automatic test_illegal();
        cycle(7'b1111111, 1'b1, 1'b0, 1'b0);
        checks++;
        if (Illegal !== 1'b1 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || ALUOp !== 2'b00 ||
            valid_out !== 1'b1 || obs !== exp_q) begin
            failures++; $display("FAIL illegal_ones: got %b expected %b", obs, exp_q);
        end
        cycle(7'bxxxxxxx, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== 14'b00000000000011) begin
            failures++; $display("FAIL illegal_x: got %b expected %b", obs, 14'b11);
        end
        exp_q = 14'b00000000000011;
        cycle(7'b1111111, 1'b0, 1'b0, 1'b0);
        checks++;
        if (Illegal !== 1'b0 || valid_out !== 1'b0 || obs !== exp_q) begin
            failures++; $display("FAIL illegal_invalid: got %b expected %b", obs, exp_q);
        end
    endtask

    task automatic test_stall();
        cycle(ST_OP, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(R_OP, 1'b1, 1'b1, 1'b0);
            checks++;
            if (MemWrite !== 1'b1 || ALUSrc !== 1'b1 || obs !== exp_q) begin
                failures++; $display("FAIL stall_hold_%0d: got %b expected %b", i, obs, exp_q);
            end
        end
        cycle(R_OP, 1'b1, 1'b0, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || ALUOp !== 2'b10 || obs !== exp_q) begin
            failures++; $display("FAIL stall_release: got %b expected %b", obs, exp_q);
        end
    endtask

    task automatic test_flush();
        cycle(LD_OP, 1'b1, 1'b0, 1'b0);
        cycle(R_OP, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== 14'd0) begin
            failures++; $display("FAIL flush_over_stall: got %b expected %b", obs, 14'd0);
        end
        cycle(BR_OP, 1'b1, 1'b0, 1'b0);
        checks++;
        if (Branch !== 1'b1 || ALUOp !== 2'b01 || obs !== exp_q) begin
            failures++; $display("FAIL flush_then_branch: got %b expected %b", obs, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic odd;
            odd = i[0];
            cycle(odd ? JALR_OP : JAL_OP, 1'b1, 1'b0, 1'b0);
            checks++;
            if (Jump !== 1'b1 || Jalr !== odd || ALUSrcA !== (odd ? 2'b00 : 2'b01) ||
                obs !== exp_q) begin
                failures++; $display("FAIL b2b_%0d: got %b expected %b", i, obs, exp_q);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 9) < 7) op = tbl_op[$urandom_range(0, 8)];
            else op = 7'($urandom);
            cycle(op, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 9) == 0));
            checks++;
            if (obs !== exp_q) begin
                failures++; $display("FAIL random_%0d op=%b: got %b expected %b", i, op, obs,
                                     exp_q);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        init_table();
        test_reset();
        test_sweep();
        test_illegal();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
